// File: rtl/icache_nwa_plru.sv
// N-way set-associative instruction cache with wide line refill, critical-word
// forwarding, whole-cache flush and saturating hit/miss counters.
module icache_nwa_plru #(
    parameter int CACHE_SIZE = 4096,
    parameter int NUM_WAYS   = 4,
    parameter int NUM_BLOCKS = 4,
    parameter int BLOCK_SIZE = 4,
    parameter int REPL_LRU   = 1
) (
    input  logic                                clk,
    input  logic                                resetn,
    input  logic                                proc_valid,
    output logic                                proc_ready,
    input  logic [31:0]                         proc_addr,
    output logic [8*BLOCK_SIZE-1:0]             proc_rdata,
    input  logic                                flush_req,
    output logic                                flush_done,
    output logic                                mem_req_valid,
    input  logic                                mem_req_ready,
    output logic [31:0]                         mem_req_addr,
    input  logic [8*BLOCK_SIZE*NUM_BLOCKS-1:0]  mem_req_rdata,
    output logic [31:0]                         perf_hits,
    output logic [31:0]                         perf_misses
);
    localparam int OB       = $clog2(NUM_BLOCKS);
    localparam int NUM_SETS = CACHE_SIZE / (NUM_BLOCKS * BLOCK_SIZE * NUM_WAYS);
    localparam int IB       = $clog2(NUM_SETS);
    localparam int TW       = 32 - IB - OB - 2;
    localparam int WB       = $clog2(NUM_WAYS);
    localparam int WORD_W   = 8 * BLOCK_SIZE;
    localparam int LINE_W   = WORD_W * NUM_BLOCKS;

    typedef enum logic [1:0] {IDLE, REFILL, DONE, FLUSH} state_t;
    state_t state, state_next;

    logic [LINE_W-1:0]   data_mem [NUM_WAYS][NUM_SETS];
    logic [TW-1:0]       tag_mem  [NUM_WAYS][NUM_SETS];
    logic [NUM_WAYS-1:0] valid    [NUM_SETS];
    logic [NUM_WAYS-2:0] plru     [NUM_SETS];
    logic [WB-1:0]       rr_ptr   [NUM_SETS];

    logic [31:0]       miss_addr;
    logic              req_dropped;
    logic              hit, victim_found, flush_go, lookup, do_hit, do_miss, install, serve;
    logic [WB-1:0]     hit_way, victim;
    logic [LINE_W-1:0] hit_line;
    logic [WORD_W-1:0] hit_word, fwd_word;
    logic              unused_bits;

    wire [TW-1:0] req_tag  = proc_addr[31 -: TW];
    wire [IB-1:0] req_idx  = proc_addr[OB+2 +: IB];
    wire [OB-1:0] req_off  = proc_addr[2 +: OB];
    wire [TW-1:0] miss_tag = miss_addr[31 -: TW];
    wire [IB-1:0] miss_idx = miss_addr[OB+2 +: IB];
    wire [OB-1:0] miss_off = miss_addr[2 +: OB];

    assign unused_bits = ^{proc_addr[1:0], miss_addr[1:0]};

    // Tree walk: a node bit of 1 points the victim search at its right subtree.
    function automatic logic [WB-1:0] plru_victim(input logic [NUM_WAYS-2:0] tree);
        int node;
        node = 0;
        for (int l = 0; l < WB; l++) node = 2 * node + 1 + int'(tree[node]);
        return WB'(node - (NUM_WAYS - 1));
    endfunction

    function automatic logic [NUM_WAYS-2:0] plru_touch(input logic [NUM_WAYS-2:0] tree,
                                                        input logic [WB-1:0] way);
        logic [NUM_WAYS-2:0] t;
        int node;
        t    = tree;
        node = 0;
        for (int l = 0; l < WB; l++) begin
            t[node] = ~way[WB-1-l];
            node    = 2 * node + 1 + int'(way[WB-1-l]);
        end
        return t;
    endfunction

    always_comb begin
        hit     = 1'b0;
        hit_way = '0;
        for (int w = 0; w < NUM_WAYS; w++) begin
            if (valid[req_idx][w] && tag_mem[w][req_idx] == req_tag) begin
                hit     = 1'b1;
                hit_way = WB'(w);
            end
        end
        hit_line = data_mem[hit_way][req_idx];
        hit_word = hit_line[int'(req_off)*WORD_W +: WORD_W];
        fwd_word = mem_req_rdata[int'(miss_off)*WORD_W +: WORD_W];
    end

    // Empty ways are always filled first, lowest index wins.
    always_comb begin
        victim       = (REPL_LRU != 0) ? plru_victim(plru[miss_idx]) : rr_ptr[miss_idx];
        victim_found = 1'b0;
        for (int w = 0; w < NUM_WAYS; w++) begin
            if (!victim_found && !valid[miss_idx][w]) begin
                victim       = WB'(w);
                victim_found = 1'b1;
            end
        end
    end

    // flush_done blocks a second flush while the requester is still releasing flush_req.
    assign flush_go = flush_req && !flush_done;
    assign lookup   = (state == IDLE) && !flush_go && proc_valid;
    assign do_hit   = lookup && hit;
    assign do_miss  = lookup && !hit;
    assign install  = (state == REFILL) && mem_req_ready;
    assign serve    = install && proc_valid && !req_dropped;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) state <= IDLE;
        else         state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (flush_go)        state_next = FLUSH;
                     else if (proc_valid) state_next = hit ? DONE : REFILL;
            REFILL:  if (mem_req_ready)   state_next = serve ? DONE : IDLE;
            DONE:    if (!proc_valid)     state_next = IDLE;
            FLUSH:                        state_next = IDLE;
            default:                      state_next = IDLE;
        endcase
    end

    always_comb begin
        mem_req_valid = 1'b0;
        mem_req_addr  = '0;
        if (state == REFILL) begin
            mem_req_valid = 1'b1;
            mem_req_addr  = {miss_addr[31:OB+2], {(OB+2){1'b0}}};
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            proc_ready  <= 1'b0;
            proc_rdata  <= '0;
            flush_done  <= 1'b0;
            perf_hits   <= '0;
            perf_misses <= '0;
            miss_addr   <= '0;
            req_dropped <= 1'b0;
        end else begin
            proc_ready <= do_hit || serve;
            flush_done <= (state == FLUSH);
            if (do_hit)      proc_rdata <= hit_word;
            else if (serve)  proc_rdata <= fwd_word;
            if (do_hit && perf_hits != '1)    perf_hits   <= perf_hits + 32'd1;
            if (do_miss && perf_misses != '1) perf_misses <= perf_misses + 32'd1;
            if (do_miss) begin
                miss_addr   <= proc_addr;
                req_dropped <= 1'b0;
            end else if (state == REFILL && !proc_valid) begin
                req_dropped <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            for (int s = 0; s < NUM_SETS; s++) begin
                valid[s]  <= '0;
                plru[s]   <= '0;
                rr_ptr[s] <= '0;
            end
        end else if (state == FLUSH) begin
            for (int s = 0; s < NUM_SETS; s++) begin
                valid[s]  <= '0;
                plru[s]   <= '0;
                rr_ptr[s] <= '0;
            end
        end else if (install) begin
            valid[miss_idx][victim] <= 1'b1;
            if (REPL_LRU != 0) plru[miss_idx]   <= plru_touch(plru[miss_idx], victim);
            else               rr_ptr[miss_idx] <= rr_ptr[miss_idx] + 1'b1;
        end else if (do_hit && REPL_LRU != 0) begin
            plru[req_idx] <= plru_touch(plru[req_idx], hit_way);
        end
    end

    always_ff @(posedge clk) begin
        if (install) begin
            data_mem[victim][miss_idx] <= mem_req_rdata;
            tag_mem[victim][miss_idx]  <= miss_tag;
        end
    end
endmodule

// File: tb/tb_icache_nwa_plru.sv
// Directed bench for icache_nwa_plru: one tree-PLRU instance (index 0) and one
// round-robin instance (index 1) driven from per-instance signal slices.
module tb_icache_nwa_plru;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic              resetn;
    logic [1:0]        proc_valid, proc_ready, flush_req, flush_done, mem_req_valid, mem_req_ready;
    logic [1:0][31:0]  proc_addr, proc_rdata, mem_req_addr, perf_hits, perf_misses;
    logic [1:0][127:0] mem_req_rdata;

    int vectors = 0;
    int errors  = 0;

    icache_nwa_plru #(.CACHE_SIZE(4096), .NUM_WAYS(4), .NUM_BLOCKS(4), .BLOCK_SIZE(4), .REPL_LRU(1)) u_lru (
        .clk(clk), .resetn(resetn),
        .proc_valid(proc_valid[0]), .proc_ready(proc_ready[0]), .proc_addr(proc_addr[0]),
        .proc_rdata(proc_rdata[0]), .flush_req(flush_req[0]), .flush_done(flush_done[0]),
        .mem_req_valid(mem_req_valid[0]), .mem_req_ready(mem_req_ready[0]),
        .mem_req_addr(mem_req_addr[0]), .mem_req_rdata(mem_req_rdata[0]),
        .perf_hits(perf_hits[0]), .perf_misses(perf_misses[0])
    );

    icache_nwa_plru #(.CACHE_SIZE(4096), .NUM_WAYS(4), .NUM_BLOCKS(4), .BLOCK_SIZE(4), .REPL_LRU(0)) u_rr (
        .clk(clk), .resetn(resetn),
        .proc_valid(proc_valid[1]), .proc_ready(proc_ready[1]), .proc_addr(proc_addr[1]),
        .proc_rdata(proc_rdata[1]), .flush_req(flush_req[1]), .flush_done(flush_done[1]),
        .mem_req_valid(mem_req_valid[1]), .mem_req_ready(mem_req_ready[1]),
        .mem_req_addr(mem_req_addr[1]), .mem_req_rdata(mem_req_rdata[1]),
        .perf_hits(perf_hits[1]), .perf_misses(perf_misses[1])
    );

    typedef struct {
        bit          rst_before;
        int          dut;
        logic [31:0] addr;
        int          delay;
        bit          exp_miss;
        logic [31:0] exp_hits;
        logic [31:0] exp_misses;
    } vec_t;

    vec_t vecs [21];

    // Backing-store contents: an address-derived pattern with one marked word.
    function automatic logic [31:0] mem_word(input logic [31:0] a);
        logic [31:0] w;
        w = {a[31:2], 2'b00} ^ 32'h5A00_00C3;
        if ({a[31:2], 2'b00} == 32'h0000_1004) w = 32'hDEAD_BEEF;
        return w;
    endfunction

    function automatic logic [127:0] mem_line(input logic [31:0] a);
        logic [127:0] l;
        for (int k = 0; k < 4; k++) l[32*k +: 32] = mem_word({a[31:4], 4'h0} + 32'(4 * k));
        return l;
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        vectors++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, actual, expected);
        end
    endtask

    task automatic applyStimulus(input int d, input logic [31:0] addr, input int delay,
                                 output bit got_ready, output logic [31:0] rdata, output int cycles,
                                 output bit mem_seen, output logic [31:0] mem_addr);
        int waited;
        got_ready = 1'b0;
        rdata     = '0;
        cycles    = 0;
        mem_seen  = 1'b0;
        mem_addr  = '0;
        waited    = 0;
        @(negedge clk);
        proc_valid[d] = 1'b1;
        proc_addr[d]  = addr;
        for (int c = 0; c < 60; c++) begin
            @(negedge clk);
            cycles++;
            mem_req_ready[d] = 1'b0;
            if (proc_ready[d]) begin
                got_ready = 1'b1;
                rdata     = proc_rdata[d];
                break;
            end
            if (mem_req_valid[d]) begin
                if (!mem_seen) mem_addr = mem_req_addr[d];
                mem_seen = 1'b1;
                if (waited == delay) begin
                    mem_req_rdata[d] = mem_line(mem_req_addr[d]);
                    mem_req_ready[d] = 1'b1;
                end else begin
                    waited++;
                end
            end
        end
        proc_valid[d]    = 1'b0;
        mem_req_ready[d] = 1'b0;
    endtask

    task automatic pulseReset();
        @(negedge clk);
        resetn = 1'b0;
        @(negedge clk);
        resetn = 1'b1;
    endtask

    task automatic waitMemReq(input int d, input string name);
        bit seen;
        seen = 1'b0;
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            if (mem_req_valid[d]) begin
                seen = 1'b1;
                break;
            end
        end
        checkOutput(name, 32'(seen), 32'd1);
    endtask

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation did not complete, got timeout, expected finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        bit          got_ready, mem_seen, seen;
        logic [31:0] rdata, mem_addr;
        int          cycles, ready_at, done_at;

        vecs[0]  = '{1'b0, 0, 32'h0000_0000, 1, 1'b1, 32'd0, 32'd1};
        vecs[1]  = '{1'b0, 0, 32'h0000_0400, 0, 1'b1, 32'd0, 32'd2};
        vecs[2]  = '{1'b0, 0, 32'h0000_0800, 2, 1'b1, 32'd0, 32'd3};
        vecs[3]  = '{1'b0, 0, 32'h0000_0C00, 1, 1'b1, 32'd0, 32'd4};
        vecs[4]  = '{1'b0, 0, 32'h0000_0000, 0, 1'b0, 32'd1, 32'd4};
        vecs[5]  = '{1'b0, 0, 32'h0000_1000, 1, 1'b1, 32'd1, 32'd5};
        vecs[6]  = '{1'b0, 0, 32'h0000_0400, 0, 1'b0, 32'd2, 32'd5};
        vecs[7]  = '{1'b0, 0, 32'h0000_0800, 1, 1'b1, 32'd2, 32'd6};
        vecs[8]  = '{1'b0, 0, 32'h0000_1000, 0, 1'b0, 32'd3, 32'd6};
        vecs[9]  = '{1'b0, 0, 32'h0000_0C00, 1, 1'b1, 32'd3, 32'd7};
        vecs[10] = '{1'b0, 1, 32'h0000_0000, 1, 1'b1, 32'd0, 32'd1};
        vecs[11] = '{1'b0, 1, 32'h0000_0400, 1, 1'b1, 32'd0, 32'd2};
        vecs[12] = '{1'b0, 1, 32'h0000_0800, 1, 1'b1, 32'd0, 32'd3};
        vecs[13] = '{1'b0, 1, 32'h0000_0C00, 1, 1'b1, 32'd0, 32'd4};
        vecs[14] = '{1'b0, 1, 32'h0000_0000, 0, 1'b0, 32'd1, 32'd4};
        vecs[15] = '{1'b0, 1, 32'h0000_1000, 1, 1'b1, 32'd1, 32'd5};
        vecs[16] = '{1'b0, 1, 32'h0000_0800, 0, 1'b0, 32'd2, 32'd5};
        vecs[17] = '{1'b0, 1, 32'h0000_0000, 1, 1'b1, 32'd2, 32'd6};
        vecs[18] = '{1'b0, 1, 32'h0000_0400, 1, 1'b1, 32'd2, 32'd7};
        vecs[19] = '{1'b1, 0, 32'h0000_1004, 3, 1'b1, 32'd0, 32'd1};
        vecs[20] = '{1'b0, 0, 32'h0000_1004, 0, 1'b0, 32'd1, 32'd1};

        resetn        = 1'b0;
        proc_valid    = '0;
        proc_addr     = '0;
        flush_req     = '0;
        mem_req_ready = '0;
        mem_req_rdata = '0;
        repeat (3) @(negedge clk);
        for (int d = 0; d < 2; d++) begin
            checkOutput($sformatf("rst%0d_proc_ready", d),    32'(proc_ready[d]),    32'd0);
            checkOutput($sformatf("rst%0d_flush_done", d),    32'(flush_done[d]),    32'd0);
            checkOutput($sformatf("rst%0d_mem_req_valid", d), 32'(mem_req_valid[d]), 32'd0);
            checkOutput($sformatf("rst%0d_mem_req_addr", d),  mem_req_addr[d],       32'd0);
            checkOutput($sformatf("rst%0d_perf_hits", d),     perf_hits[d],          32'd0);
            checkOutput($sformatf("rst%0d_perf_misses", d),   perf_misses[d],        32'd0);
        end
        resetn = 1'b1;

        for (int i = 0; i < 21; i++) begin
            if (vecs[i].rst_before) pulseReset();
            applyStimulus(vecs[i].dut, vecs[i].addr, vecs[i].delay, got_ready, rdata, cycles, mem_seen, mem_addr);
            checkOutput($sformatf("v%0d_ready", i), 32'(got_ready), 32'd1);
            checkOutput($sformatf("v%0d_rdata", i), rdata, mem_word(vecs[i].addr));
            checkOutput($sformatf("v%0d_miss", i), 32'(mem_seen), 32'(vecs[i].exp_miss));
            if (vecs[i].exp_miss)
                checkOutput($sformatf("v%0d_mem_addr", i), mem_addr, {vecs[i].addr[31:4], 4'h0});
            checkOutput($sformatf("v%0d_latency", i), 32'(cycles),
                        vecs[i].exp_miss ? 32'(vecs[i].delay + 2) : 32'd1);
            checkOutput($sformatf("v%0d_hits", i),   perf_hits[vecs[i].dut],   vecs[i].exp_hits);
            checkOutput($sformatf("v%0d_misses", i), perf_misses[vecs[i].dut], vecs[i].exp_misses);
        end

        // Flush after the 0x1004 hit: done two edges after the request, then a cold miss.
        @(negedge clk);
        flush_req[0] = 1'b1;
        cycles = 0;
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            cycles++;
            if (flush_done[0]) break;
        end
        flush_req[0] = 1'b0;
        checkOutput("flush_latency", 32'(cycles), 32'd2);
        @(negedge clk);
        checkOutput("flush_done_pulse", 32'(flush_done[0]), 32'd0);
        applyStimulus(0, 32'h0000_1004, 1, got_ready, rdata, cycles, mem_seen, mem_addr);
        checkOutput("flush_refetch_miss", 32'(mem_seen), 32'd1);
        checkOutput("flush_refetch_rdata", rdata, 32'hDEAD_BEEF);
        checkOutput("flush_refetch_misses", perf_misses[0], 32'd2);

        // Requester walks away mid-refill: line still lands, no response.
        @(negedge clk);
        proc_valid[0] = 1'b1;
        proc_addr[0]  = 32'h0000_2008;
        waitMemReq(0, "drop_mem_req");
        proc_valid[0] = 1'b0;
        repeat (2) @(negedge clk);
        mem_req_rdata[0] = mem_line(32'h0000_2000);
        mem_req_ready[0] = 1'b1;
        @(negedge clk);
        mem_req_ready[0] = 1'b0;
        seen = proc_ready[0];
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            if (proc_ready[0]) seen = 1'b1;
        end
        checkOutput("drop_no_ready", 32'(seen), 32'd0);
        checkOutput("drop_req_released", 32'(mem_req_valid[0]), 32'd0);
        applyStimulus(0, 32'h0000_2008, 0, got_ready, rdata, cycles, mem_seen, mem_addr);
        checkOutput("drop_refetch_hit", 32'(mem_seen), 32'd0);
        checkOutput("drop_refetch_rdata", rdata, mem_word(32'h0000_2008));
        checkOutput("drop_hits", perf_hits[0], 32'd2);
        checkOutput("drop_misses", perf_misses[0], 32'd3);

        // Flush raised during a refill: response first, then flush, and the line is gone.
        @(negedge clk);
        proc_valid[0] = 1'b1;
        proc_addr[0]  = 32'h0000_3000;
        waitMemReq(0, "fr_mem_req");
        flush_req[0] = 1'b1;
        ready_at = -1;
        done_at  = -1;
        for (int c = 1; c < 30; c++) begin
            @(negedge clk);
            mem_req_ready[0] = 1'b0;
            if (c == 2) begin
                mem_req_rdata[0] = mem_line(32'h0000_3000);
                mem_req_ready[0] = 1'b1;
            end
            if (proc_ready[0] && ready_at < 0) begin
                ready_at      = c;
                rdata         = proc_rdata[0];
                proc_valid[0] = 1'b0;
            end
            if (flush_done[0]) begin
                done_at      = c;
                flush_req[0] = 1'b0;
                break;
            end
        end
        flush_req[0]  = 1'b0;
        proc_valid[0] = 1'b0;
        checkOutput("fr_ready_seen", 32'(ready_at > 0), 32'd1);
        checkOutput("fr_rdata", rdata, mem_word(32'h0000_3000));
        checkOutput("fr_done_after_ready", 32'(done_at > ready_at), 32'd1);
        applyStimulus(0, 32'h0000_3000, 0, got_ready, rdata, cycles, mem_seen, mem_addr);
        checkOutput("fr_line_invalid", 32'(mem_seen), 32'd1);
        checkOutput("fr_misses", perf_misses[0], 32'd5);

        // Asynchronous reset in the middle of a refill.
        @(negedge clk);
        proc_valid[0] = 1'b1;
        proc_addr[0]  = 32'h0000_4000;
        waitMemReq(0, "ar_mem_req");
        #2 resetn = 1'b0;
        #1;
        checkOutput("ar_mem_req_drop", 32'(mem_req_valid[0]), 32'd0);
        checkOutput("ar_misses_clear", perf_misses[0], 32'd0);
        @(negedge clk);
        proc_valid[0] = 1'b0;
        @(negedge clk);
        resetn = 1'b1;
        @(negedge clk);
        checkOutput("ar_hits_after", perf_hits[0], 32'd0);
        applyStimulus(0, 32'h0000_4000, 1, got_ready, rdata, cycles, mem_seen, mem_addr);
        checkOutput("ar_refetch_miss", 32'(mem_seen), 32'd1);
        checkOutput("ar_refetch_rdata", rdata, mem_word(32'h0000_4000));
        checkOutput("ar_misses_after", perf_misses[0], 32'd1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end
endmodule
